// File: rtl/rv_decode_pkg.sv
// RV32I decode vocabulary shared by the decode stage: opcodes, ALU select, immediate formats.
// Latency: none, definitions only.
// Backpressure: not applicable.
package rv_decode_pkg;

  // Major opcodes (instr[6:0]) of the RV32I base set handled by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 values that are legal for ALU operations
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alusel_e;

  // IMM_R doubles as "no immediate": the generator returns zero for it
  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_fmt_e;

  // Everything the EX stage receives except the XLEN-wide immediate
  typedef struct packed {
    logic    valid;
    logic    load;
    logic    store;
    logic    branch;
    logic    jump;
    logic    reg_write;
    logic    use_imm;
    logic    illegal;
    alusel_e alusel;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_ctrl_t;

  // Map funct3 plus the funct7[5] alternate bit onto the ALU select.
  // Callers decide when the alternate bit is meaningful.
  function automatic alusel_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alusel_e sel;
    case (funct3)
      3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the RV32I formats, sign-extended from instr[31] to XLEN.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Reassemble the scattered immediate bits of each format into a 32-bit value
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format already carries instr[31] in bit 31, so a signed resize extends it
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_ctrl_stage.sv
// RV32I decode stage: turns id_instr into registered EX control with a load-use interlock.
// Latency: one cycle from an ID accept to the decoded word on the ex_* outputs.
// Backpressure: ex_ready=0 freezes a valid EX word; id_ready drops on stall or load-use hazard; flush overrides both.
module decode_ctrl_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit HAZARD_EN    = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic            ex_load,
  output logic            ex_store,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_reg_write,
  output logic            ex_use_imm,
  output logic            ex_illegal,
  output logic [3:0]      ex_alusel,
  output logic [2:0]      ex_funct3,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd
);

  // Raw instruction fields
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] f_rd;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;

  assign opcode = id_instr[6:0];
  assign f_rd   = id_instr[11:7];
  assign f3     = id_instr[14:12];
  assign f_rs1  = id_instr[19:15];
  assign f_rs2  = id_instr[24:20];
  assign f7     = id_instr[31:25];

  // Decoded (next) EX word and the registered (current) EX word
  ex_ctrl_t        dec;
  imm_fmt_e        dec_fmt;
  logic            dec_legal;
  logic [XLEN-1:0] dec_imm;

  ex_ctrl_t        ex_q;
  logic [XLEN-1:0] ex_imm_q;

  logic            hazard;
  logic            accept;

  // Classify the opcode, fill the control word, then squash it if the encoding is not legal
  always_comb begin
    dec        = '0;
    dec.alusel = ALU_ADD;
    dec_fmt    = IMM_R;
    dec_legal  = 1'b0;

    case (opcode)
      OPC_OP: begin
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding
        dec_legal     = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.alusel    = alu_from_funct(f3, f7[5]);
        dec.reg_write = 1'b1;
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec_fmt       = IMM_R;
      end

      OPC_OP_IMM: begin
        // Shift-immediates reuse imm[11:5] as funct7; every other funct3 has a free immediate
        case (f3)
          3'b001:  dec_legal = (f7 == F7_BASE);
          3'b101:  dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
        dec.alusel    = alu_from_funct(f3, (f3 == 3'b101) && f7[5]);
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec_fmt       = IMM_I;
      end

      OPC_LOAD: begin
        // LB, LH, LW, LBU, LHU
        dec_legal     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
        dec.load      = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec_fmt       = IMM_I;
      end

      OPC_STORE: begin
        // SB, SH, SW
        dec_legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        dec.store   = 1'b1;
        dec.use_imm = 1'b1;
        dec.rs1     = f_rs1;
        dec.rs2     = f_rs2;
        dec.funct3  = f3;
        dec_fmt     = IMM_S;
      end

      OPC_BRANCH: begin
        // funct3 010/011 are unassigned; the comparison runs on the subtractor
        dec_legal  = (f3 != 3'b010) && (f3 != 3'b011);
        dec.branch = 1'b1;
        dec.alusel = ALU_SUB;
        dec.rs1    = f_rs1;
        dec.rs2    = f_rs2;
        dec.funct3 = f3;
        dec_fmt    = IMM_B;
      end

      OPC_JAL: begin
        dec_legal     = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.rd        = f_rd;
        dec_fmt       = IMM_J;
      end

      OPC_JALR: begin
        dec_legal     = (f3 == 3'b000);
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec_fmt       = IMM_I;
      end

      OPC_LUI: begin
        dec_legal     = 1'b1;
        dec.alusel    = ALU_PASSB;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.rd        = f_rd;
        dec_fmt       = IMM_U;
      end

      OPC_AUIPC: begin
        dec_legal     = 1'b1;
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.rd        = f_rd;
        dec_fmt       = IMM_U;
      end

      default: begin
        dec_legal = 1'b0;
      end
    endcase

    // Writes to x0 are architecturally discarded
    if (dec.rd == 5'd0) begin
      dec.reg_write = 1'b0;
    end

    // Unknown encodings either trap with every control bit low, or become addi x0,x0,0
    if (!dec_legal) begin
      dec     = '0;
      dec_fmt = IMM_R;
      if (ILLEGAL_TRAP) begin
        dec.illegal = 1'b1;
      end else begin
        dec.use_imm = 1'b1;
      end
    end

    dec.valid = 1'b1;
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (id_instr[31:7]),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  // Load-use: the load in EX targets a register this instruction reads.
  // dec.rs1/dec.rs2 are already zero for operands the format does not use.
  assign hazard = HAZARD_EN && ex_q.valid && ex_q.load && (ex_q.rd != 5'd0) &&
                  ((ex_q.rd == dec.rs1) || (ex_q.rd == dec.rs2));

  // A flush empties EX this edge, so ID can always hand over (the word is dropped anyway)
  assign id_ready = flush || ((ex_ready || !ex_q.valid) && !hazard);
  assign accept   = id_valid && id_ready;

  // Pipeline register: flush clears, EX stall holds, accept loads, anything else is a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_imm_q <= '0;
    end else if (flush) begin
      ex_q     <= '0;
      ex_imm_q <= '0;
    end else if (ex_q.valid && !ex_ready) begin
      ex_q     <= ex_q;
      ex_imm_q <= ex_imm_q;
    end else if (accept) begin
      ex_q     <= dec;
      ex_imm_q <= dec_imm;
    end else begin
      ex_q     <= '0;
      ex_imm_q <= '0;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_load      = ex_q.load;
  assign ex_store     = ex_q.store;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_use_imm   = ex_q.use_imm;
  assign ex_illegal   = ex_q.illegal;
  assign ex_alusel    = ex_q.alusel;
  assign ex_funct3    = ex_q.funct3;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_imm       = ex_imm_q;

endmodule
